nios2_ht18_wang_fu_irq_ctrl: RTL and testbench
==============================================

# nios2_ht18_wang_fu_irq_ctrl

Avalon-MM slave interrupt controller sitting directly downstream of the interval timer and the other peripheral interrupt sources. It collects up to NUM_IRQ source lines (timer irq on bit 0), latches them per-source as edge or level events, masks them, and presents one registered irq to the Nios II plus a priority-encoded vector register. A programmable hold-off counter suppresses re-assertion after software acknowledge.

## Interface
- NUM_IRQ, 8, number of source lines; legal 1..15
- HOLDOFF_W, 16, width of hold-off register and counter
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset, synchronous and active-low
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- irq_in  in  NUM_IRQ  source interrupt lines, same clock domain, bit 0 = timer
- readdata  out  16  registered read data
- irq  out  1  registered interrupt to CPU

## Operation
- wr(a) = chipselect && ~write_n && address==a. Reads need no strobe: readdata <= mux(address) every cycle.
- Register map (unused bits read 0):
  - 0 STATUS (RO): pending & mask.
  - 1 PENDING (R, W1C): pending bits; writedata bit i=1 clears source i if edge mode.
  - 2 MASK (RW): per-source enable.
  - 3 MODE (RW): 1 = edge, 0 = level.
  - 4 VECTOR (RO data, write = ACK): bit15 = any active; bits 3:0 = lowest index i with pending[i]&mask[i]; 0x0000 if none.
  - 5 HOLDOFF (RW): hold-off length in cycles, bits HOLDOFF_W-1:0.
  - 6 RAW (RO): irq_s (sampled inputs).
  - 7 reserved, reads 0, writes ignored.
- Input stage: irq_s <= irq_in; irq_d <= irq_s. rise[i] = irq_s[i] & ~irq_d[i].
- Pending, level source: pending[i] <= irq_s[i] every cycle; W1C and ACK have no effect.
- Pending, edge source: set on rise[i]; cleared by W1C bit i or ACK targeting i; set wins when set and clear occur in the same cycle.
- ACK (any write to address 4): clears pending of the source currently indicated by VECTOR (value before the write, only if valid and edge mode) and loads holdoff_cnt <= HOLDOFF.
- Any W1C write to address 1 also loads holdoff_cnt <= HOLDOFF.
- holdoff_cnt decrements by 1 per cycle while nonzero, saturates at 0. Writing HOLDOFF does not alter a running count.
- irq <= |(pending & mask) && holdoff_cnt==0 (uses post-update-free current values, i.e. register inputs are current-cycle state).
- Changing MODE from level to edge leaves pending as-is; from edge to level, pending follows irq_s from the next cycle.
- Reset values: readdata 0, irq 0, irq_s 0, irq_d 0, pending 0, MASK 0, MODE 0, HOLDOFF 0, holdoff_cnt 0.

## Timing
- Read latency 1: address presented at edge k, data valid after edge k; reflects state before any same-cycle write.
- Source to irq: irq_in high before edge k -> irq_s=1 after k -> pending=1 after k+1 -> irq=1 after k+2 (mask already set).
- Mask write at edge k -> irq reflects new mask after k+1.
- ACK at edge k -> pending cleared and holdoff_cnt=HOLDOFF after k; irq=0 after k+1 if HOLDOFF>0 or nothing else pending; with HOLDOFF=H, irq may reassert earliest after edge k+H+1.
- HOLDOFF=0: no suppression; irq drops after k+1 only if nothing remains pending.
- Reset asserted at any edge overrides all writes and events in that cycle; all state returns to reset values after that edge.
- Single-cycle pulse on irq_in is always captured in edge mode; in level mode it produces a one-cycle pending.

## Test plan
- Reset: hold reset_n=0 two cycles with irq_in=all ones -> readdata=0, irq=0; after release, RAW read = 0x00FF, STATUS = 0.
- Timer edge: MODE=0x01, MASK=0x01, pulse irq_in[0] one cycle before edge k -> irq=1 after k+2; VECTOR reads 0x8000; ACK -> PENDING reads 0, irq=0.
- Priority: edge sources 2 and 5 pending, MASK=0x24 -> VECTOR 0x8002; ACK -> VECTOR 0x8005; ACK -> 0x0000.
- Hold-off: HOLDOFF=10, source 0 re-pulses every cycle after ACK at edge k -> irq=0 through edge k+10, irq=1 after k+11.
- Set/clear collision: W1C bit 3 in same cycle as rise[3] (edge mode) -> PENDING bit 3 remains 1.
- Level mode: MODE=0, MASK=0x02, irq_in[1] high 5 cycles -> irq high 5 cycles delayed by 3; W1C 0x0002 mid-assertion leaves PENDING bit 1 = 1.

Source files
------------

// File: rtl/nios2_ht18_wang_fu_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// nios2_ht18_wang_fu_irq_ctrl_if
// Avalon-MM slave register bus for the interrupt controller.
//   address     3-bit register word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   16-bit write data
//   readdata    16-bit registered read data (driven by the slave)
// Modports: master (CPU/bus side), slave (controller side).
// ---------------------------------------------------------------------------
interface nios2_ht18_wang_fu_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_ht18_wang_fu_irq_ctrl.sv
// ---------------------------------------------------------------------------
// nios2_ht18_wang_fu_irq_ctrl
// Interrupt controller for the Nios II: samples NUM_IRQ source lines
// (bit 0 = interval timer), latches each as an edge or level event, masks
// them, and drives one registered irq plus a priority-encoded vector.
// A programmable hold-off count suppresses irq after a software acknowledge.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   reset_n  synchronous active-low reset
//   bus      Avalon-MM slave register interface (address/chipselect/
//            write_n/writedata in, readdata out, read latency 1)
//   irq_in   source interrupt lines, same clock domain
//   irq      registered interrupt request to the CPU
//
// Register map (word address):
//   0 STATUS  (RO)   pending & mask
//   1 PENDING (W1C)  pending bits; W1C only affects edge-mode sources
//   2 MASK    (RW)   per-source enable
//   3 MODE    (RW)   1 = edge, 0 = level
//   4 VECTOR  (RO, write = ACK) {any, 11'b0, lowest active index}
//   5 HOLDOFF (RW)   hold-off length in cycles
//   6 RAW     (RO)   sampled inputs
//   7 reserved, reads 0
// ---------------------------------------------------------------------------
module nios2_ht18_wang_fu_irq_ctrl #(
  parameter int NUM_IRQ   = 8,
  parameter int HOLDOFF_W = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  nios2_ht18_wang_fu_irq_ctrl_if.slave bus,
  input  logic [NUM_IRQ-1:0]           irq_in,
  output logic                         irq
);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd5;
  localparam logic [2:0] ADDR_RAW     = 3'd6;

  localparam logic [HOLDOFF_W-1:0] CNT_ONE = HOLDOFF_W'(1);

  logic [NUM_IRQ-1:0]   irq_s;
  logic [NUM_IRQ-1:0]   irq_d;
  logic [NUM_IRQ-1:0]   pending;
  logic [NUM_IRQ-1:0]   mask;
  logic [NUM_IRQ-1:0]   mode;
  logic [HOLDOFF_W-1:0] holdoff;
  logic [HOLDOFF_W-1:0] holdoff_cnt;

  logic                 wr_en;
  logic                 ack;
  logic                 w1c;
  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   active;
  logic                 any_active;
  logic [3:0]           vec_idx;
  logic [NUM_IRQ-1:0]   ack_sel;
  logic [NUM_IRQ-1:0]   clr;
  logic [NUM_IRQ-1:0]   pending_nxt;
  logic [15:0]          vector;
  logic [15:0]          read_mux;

  assign wr_en = bus.chipselect && !bus.write_n;
  assign ack   = wr_en && (bus.address == ADDR_VECTOR);
  assign w1c   = wr_en && (bus.address == ADDR_PENDING);

  assign rise       = irq_s & ~irq_d;
  assign active     = pending & mask;
  assign any_active = |active;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 4'(i);
    end
  end

  assign vector = any_active ? {1'b1, 11'd0, vec_idx} : 16'h0000;

  // ACK clears the source the vector pointed at before this write.
  always_comb begin
    ack_sel = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_sel[i] = ack && any_active && (vec_idx == 4'(i));
    end
  end

  assign clr = ({NUM_IRQ{w1c}} & bus.writedata[NUM_IRQ-1:0]) | ack_sel;

  // Edge sources: a rising edge beats a same-cycle clear.
  // Level sources: pending simply tracks the sampled input.
  assign pending_nxt = (mode & (rise | (pending & ~clr))) | (~mode & irq_s);

  always_comb begin
    read_mux = 16'h0000;
    case (bus.address)
      ADDR_STATUS:  read_mux = 16'(active);
      ADDR_PENDING: read_mux = 16'(pending);
      ADDR_MASK:    read_mux = 16'(mask);
      ADDR_MODE:    read_mux = 16'(mode);
      ADDR_VECTOR:  read_mux = vector;
      ADDR_HOLDOFF: read_mux = 16'(holdoff);
      ADDR_RAW:     read_mux = 16'(irq_s);
      default:      read_mux = 16'h0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_s        <= '0;
      irq_d        <= '0;
      pending      <= '0;
      mask         <= '0;
      mode         <= '0;
      holdoff      <= '0;
      holdoff_cnt  <= '0;
      irq          <= 1'b0;
      bus.readdata <= 16'h0000;
    end else begin
      irq_s        <= irq_in;
      irq_d        <= irq_s;
      pending      <= pending_nxt;
      bus.readdata <= read_mux;

      if (wr_en && (bus.address == ADDR_MASK))    mask    <= bus.writedata[NUM_IRQ-1:0];
      if (wr_en && (bus.address == ADDR_MODE))    mode    <= bus.writedata[NUM_IRQ-1:0];
      if (wr_en && (bus.address == ADDR_HOLDOFF)) holdoff <= bus.writedata[HOLDOFF_W-1:0];

      // A reload uses the hold-off length held before any same-cycle write.
      if (ack || w1c)                holdoff_cnt <= holdoff;
      else if (holdoff_cnt != '0)    holdoff_cnt <= holdoff_cnt - CNT_ONE;

      irq <= any_active && (holdoff_cnt == '0);
    end
  end

endmodule

// File: tb/tb_nios2_ht18_wang_fu_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nios2_ht18_wang_fu_irq_ctrl
// Self-checking bench for the interrupt controller. Directed scenarios follow
// the documented behaviour; a randomized phase compares every cycle against
// a behavioural model held in per-source arrays.
// ---------------------------------------------------------------------------
module tb_nios2_ht18_wang_fu_irq_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] irq_in;
  logic         irq;

  nios2_ht18_wang_fu_irq_ctrl_if bus ();

  nios2_ht18_wang_fu_irq_ctrl #(
    .NUM_IRQ   (N),
    .HOLDOFF_W (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  bit m_sync [N];   // last sampled input
  bit m_prev [N];   // sample before that
  bit m_pend [N];
  bit m_mask [N];
  bit m_edge [N];
  int m_hold_len;
  int m_hold_left;
  int m_rd;
  bit m_irq;

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  first;
    int  rd_v;
    bit  wr, ack, w1c;
    bit  new_pend [N];
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_sync[i] = 0; m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = 0;
      end
      m_hold_len = 0; m_hold_left = 0; m_rd = 0; m_irq = 0;
      return;
    end
    first = -1;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && m_mask[i]) begin
        first = i;
        break;
      end
    end
    rd_v = 0;
    for (int i = 0; i < N; i++) begin
      case (bus.address)
        3'd0: if (m_pend[i] && m_mask[i]) rd_v += (1 << i);
        3'd1: if (m_pend[i]) rd_v += (1 << i);
        3'd2: if (m_mask[i]) rd_v += (1 << i);
        3'd3: if (m_edge[i]) rd_v += (1 << i);
        3'd6: if (m_sync[i]) rd_v += (1 << i);
        default: ;
      endcase
    end
    if (bus.address == 3'd4) rd_v = (first < 0) ? 0 : 32768 + first;
    if (bus.address == 3'd5) rd_v = m_hold_len;

    wr  = bus.chipselect && !bus.write_n;
    ack = wr && bus.address == 3'd4;
    w1c = wr && bus.address == 3'd1;

    for (int i = 0; i < N; i++) begin
      if (!m_edge[i])                           new_pend[i] = m_sync[i];
      else if (m_sync[i] && !m_prev[i])         new_pend[i] = 1;
      else if ((w1c && bus.writedata[i]) || (ack && first == i)) new_pend[i] = 0;
      else                                      new_pend[i] = m_pend[i];
    end

    m_irq = (first >= 0) && (m_hold_left == 0);
    m_rd  = rd_v;
    if (ack || w1c)          m_hold_left = m_hold_len;
    else if (m_hold_left > 0) m_hold_left = m_hold_left - 1;

    for (int i = 0; i < N; i++) begin
      m_pend[i] = new_pend[i];
      if (wr && bus.address == 3'd2) m_mask[i] = bus.writedata[i];
      if (wr && bus.address == 3'd3) m_edge[i] = bus.writedata[i];
      m_prev[i] = m_sync[i];
      m_sync[i] = irq_in[i];
    end
    if (wr && bus.address == 3'd5) m_hold_len = int'(bus.writedata);
  endtask

  // One clock: model advances with the same inputs, outputs settle #1 later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    bus.address = a; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    tick();
    d = bus.readdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] v;
    reset_n = 1'b0; irq_in = '1;
    bus.address = 3'd6; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (bus.readdata !== 16'h0000) begin
        n_bad++; $display("FAIL reset_readdata cycle %0d: got %h want 0000", c, bus.readdata);
      end
      n_cmp++;
      if (irq !== 1'b0) begin
        n_bad++; $display("FAIL reset_irq cycle %0d: got %b want 0", c, irq);
      end
    end
    reset_n = 1'b1;
    tick();
    bus_read(3'd6, v);
    n_cmp++;
    if (v !== 16'h00FF) begin n_bad++; $display("FAIL reset_raw: got %h want 00ff", v); end
    bus_read(3'd0, v);
    n_cmp++;
    if (v !== 16'h0000) begin n_bad++; $display("FAIL reset_status: got %h want 0000", v); end
    irq_in = '0;
    repeat (3) tick();
  endtask

  task automatic test_timer_edge();
    logic [15:0] v;
    bus_write(3'd3, 16'h0001);
    bus_write(3'd2, 16'h0001);
    irq_in = 8'h01;
    tick();                       // edge k: sampled
    irq_in = 8'h00;
    tick();                       // k+1: pending set
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL timer_irq_k1: got %b want 0", irq); end
    tick();                       // k+2: irq
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL timer_irq_k2: got %b want 1", irq); end
    bus_read(3'd4, v);
    n_cmp++;
    if (v !== 16'h8000) begin n_bad++; $display("FAIL timer_vector: got %h want 8000", v); end
    bus_write(3'd4, 16'h0000);    // ACK
    bus_read(3'd1, v);
    n_cmp++;
    if (v !== 16'h0000) begin n_bad++; $display("FAIL timer_pending_after_ack: got %h want 0000", v); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL timer_irq_after_ack: got %b want 0", irq); end
  endtask

  task automatic test_priority();
    logic [15:0] v;
    bus_write(3'd3, 16'h00FF);
    bus_write(3'd2, 16'h0024);
    irq_in = 8'h24;
    tick();
    irq_in = 8'h00;
    tick(); tick();
    bus_read(3'd4, v);
    n_cmp++;
    if (v !== 16'h8002) begin n_bad++; $display("FAIL prio_vec_first: got %h want 8002", v); end
    bus_write(3'd4, 16'h0000);
    bus_read(3'd4, v);
    n_cmp++;
    if (v !== 16'h8005) begin n_bad++; $display("FAIL prio_vec_second: got %h want 8005", v); end
    bus_write(3'd4, 16'h0000);
    bus_read(3'd4, v);
    n_cmp++;
    if (v !== 16'h0000) begin n_bad++; $display("FAIL prio_vec_empty: got %h want 0000", v); end
  endtask

  task automatic test_holdoff();
    bus_write(3'd2, 16'h0001);
    bus_write(3'd5, 16'd10);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick(); tick();
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL holdoff_pre_irq: got %b want 1", irq); end
    // ACK at edge k while the source keeps pulsing.
    irq_in = 8'h01;
    bus_write(3'd4, 16'h0000);
    for (int j = 1; j <= 11; j++) begin
      irq_in[0] = ~irq_in[0];
      tick();
      n_cmp++;
      if (irq !== (j == 11)) begin
        n_bad++; $display("FAIL holdoff_irq_k%0d: got %b want %0d", j, irq, (j == 11));
      end
    end
    irq_in = '0;
    bus_write(3'd5, 16'd0);
    repeat (3) tick();
    bus_write(3'd1, 16'h00FF);
  endtask

  task automatic test_collision();
    logic [15:0] v;
    irq_in = 8'h08;
    tick();
    bus_write(3'd1, 16'h0008);    // W1C in the same edge as rise[3]
    irq_in = 8'h00;
    bus_read(3'd1, v);
    n_cmp++;
    if (v[3] !== 1'b1) begin n_bad++; $display("FAIL collision_pending3: got %b want 1", v[3]); end
    n_cmp++;
    if (v !== m_rd[15:0]) begin n_bad++; $display("FAIL collision_pending_word: got %h want %h", v, m_rd[15:0]); end
  endtask

  task automatic test_level();
    bus_write(3'd3, 16'h0000);
    bus_write(3'd2, 16'h0002);
    irq_in = '0;
    repeat (2) tick();
    for (int j = 0; j < 10; j++) begin
      irq_in[1] = (j < 5);
      bus.address = 3'd1; bus.writedata = 16'h0002;
      bus.chipselect = (j == 2); bus.write_n = (j != 2);
      tick();
      n_cmp++;
      if (irq !== (j >= 2 && j <= 6)) begin
        n_bad++; $display("FAIL level_irq_k%0d: got %b want %0d", j, irq, (j >= 2 && j <= 6));
      end
      if (j == 3) begin
        n_cmp++;
        if (bus.readdata[1] !== 1'b1) begin
          n_bad++; $display("FAIL level_w1c_ignored: got %b want 1", bus.readdata[1]);
        end
      end
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset_n        = ($urandom_range(0, 149) != 0);
      bus.address    = 3'($urandom_range(0, 7));
      bus.chipselect = 1'($urandom_range(0, 1));
      bus.write_n    = ($urandom_range(0, 2) != 0);
      bus.writedata  = (bus.address == 3'd5) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      irq_in         = N'($urandom);
      tick();
      n_cmp++;
      if (bus.readdata !== m_rd[15:0]) begin
        n_bad++; $display("FAIL rand_readdata cycle %0d: got %h want %h", c, bus.readdata, m_rd[15:0]);
      end
      n_cmp++;
      if (irq !== m_irq) begin
        n_bad++; $display("FAIL rand_irq cycle %0d: got %b want %b", c, irq, m_irq);
      end
    end
    reset_n = 1'b1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; irq_in = '0;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    test_reset();
    test_timer_edge();
    test_priority();
    test_holdoff();
    test_collision();
    test_level();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
